// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and field layout for the imem/dmem memory port arbiter
package mem_arb_pkg;

    localparam int REQ_ADDR_WIDTH = 32;
    localparam int REQ_DATA_WIDTH = 32;
    localparam int MEM_OP_SIZE    = 68;

    localparam int BYTE_EN_LSB = 64;
    localparam int ADDR_LSB    = 32;
    localparam int DATA_LSB    = 0;

    typedef enum logic {
        CLIENT_IMEM = 1'b0,
        CLIENT_DMEM = 1'b1
    } client_id_t;

    typedef struct packed {
        logic [3:0]                byte_en;
        logic [REQ_ADDR_WIDTH-1:0] addr;
        logic [REQ_DATA_WIDTH-1:0] data;
    } mem_op_t;

    function automatic client_id_t other_client(input client_id_t c);
        return (c == CLIENT_IMEM) ? CLIENT_DMEM : CLIENT_IMEM;
    endfunction

endpackage

// File: rtl/owner_fifo.sv
// rtl/owner_fifo.sv - in-order tag FIFO recording which client owns each outstanding memory request
module owner_fifo
    import mem_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       push_i,
    input  client_id_t push_id_i,
    input  logic       pop_i,
    output logic       full_o,
    output logic       empty_o,
    output client_id_t head_o
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    if (DEPTH < 1) begin : g_bad_depth
        $error("owner_fifo DEPTH must be at least 1");
    end

    client_id_t       tag_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = tag_q[rd_ptr_q];

    // Full refuses a push even when a pop frees a slot in the same cycle.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push) begin
            tag_q[wr_ptr_q] <= push_id_i;
        end
    end

`ifndef SYNTHESIS
    always @(posedge CLK) begin
        if (RST_N) begin
            assert (!(push_i && full_o)) else $error("owner_fifo: push while full");
            assert (!(pop_i && empty_o)) else $error("owner_fifo: pop while empty");
        end
    end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin sharing of one memory port between imem (c0) and dmem (c1)
// Define ARB_STATS_EN to add the grant and conflict counters.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int OP_WIDTH    = MEM_OP_SIZE,
    parameter int OWNER_DEPTH = 2
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                c0_put_enable,
    input  logic [OP_WIDTH-1:0] c0_put_request,
    output logic                c0_put_ready,
    input  logic                c0_get_enable,
    output logic                c0_get_ready,
    output logic [OP_WIDTH-1:0] c0_get_response,
    input  logic                c1_put_enable,
    input  logic [OP_WIDTH-1:0] c1_put_request,
    output logic                c1_put_ready,
    input  logic                c1_get_enable,
    output logic                c1_get_ready,
    output logic [OP_WIDTH-1:0] c1_get_response,
    output logic                mem_put_enable,
    output logic [OP_WIDTH-1:0] mem_put_request,
    input  logic                mem_put_ready,
    output logic                mem_get_enable,
    input  logic                mem_get_ready,
    input  logic [OP_WIDTH-1:0] mem_get_response
`ifdef ARB_STATS_EN
    ,
    output logic [31:0]         stat_grants0,
    output logic [31:0]         stat_grants1,
    output logic [31:0]         stat_conflicts
`endif
);

    client_id_t prio_q, prio_d;
    client_id_t owner_head;
    logic       owner_full, owner_empty;
    logic       can_issue;
    logic       c0_xfer, c1_xfer;
    logic       resp_valid;

    assign can_issue    = RST_N && mem_put_ready && !owner_full;
    assign c0_put_ready = can_issue && (prio_q == CLIENT_IMEM || !c1_put_enable);
    assign c1_put_ready = can_issue && (prio_q == CLIENT_DMEM || !c0_put_enable);
    assign c0_xfer      = c0_put_enable && c0_put_ready;
    assign c1_xfer      = c1_put_enable && c1_put_ready;

    assign mem_put_enable  = c0_xfer || c1_xfer;
    assign mem_put_request = c1_xfer ? c1_put_request : c0_put_request;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            prio_q <= CLIENT_IMEM;
        end else begin
            prio_q <= prio_d;
        end
    end

    always_comb begin
        prio_d = prio_q;
        if (c0_xfer) begin
            prio_d = other_client(CLIENT_IMEM);
        end else if (c1_xfer) begin
            prio_d = other_client(CLIENT_DMEM);
        end
    end

    owner_fifo #(
        .DEPTH (OWNER_DEPTH)
    ) u_owner_fifo (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .push_i    (mem_put_enable),
        .push_id_i (c1_xfer ? CLIENT_DMEM : CLIENT_IMEM),
        .pop_i     (mem_get_enable),
        .full_o    (owner_full),
        .empty_o   (owner_empty),
        .head_o    (owner_head)
    );

    // Only the client owning the oldest outstanding request sees the response.
    assign resp_valid      = RST_N && mem_get_ready && !owner_empty;
    assign c0_get_ready    = resp_valid && (owner_head == CLIENT_IMEM);
    assign c1_get_ready    = resp_valid && (owner_head == CLIENT_DMEM);
    assign c0_get_response = mem_get_response;
    assign c1_get_response = mem_get_response;
    assign mem_get_enable  = (c0_get_enable && c0_get_ready) || (c1_get_enable && c1_get_ready);

`ifdef ARB_STATS_EN
    logic [31:0] stat_grants0_q, stat_grants1_q, stat_conflicts_q;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            stat_grants0_q   <= '0;
            stat_grants1_q   <= '0;
            stat_conflicts_q <= '0;
        end else begin
            if (c0_xfer) begin
                stat_grants0_q <= stat_grants0_q + 32'd1;
            end
            if (c1_xfer) begin
                stat_grants1_q <= stat_grants1_q + 32'd1;
            end
            if (c0_put_enable && c1_put_enable && can_issue) begin
                stat_conflicts_q <= stat_conflicts_q + 32'd1;
            end
        end
    end

    assign stat_grants0   = stat_grants0_q;
    assign stat_grants1   = stat_grants1_q;
    assign stat_conflicts = stat_conflicts_q;
`endif

`ifndef SYNTHESIS
    always @(posedge CLK) begin
        if (RST_N) begin
            assert (!(mem_get_ready && owner_empty))
                else $error("mem_port_arbiter: memory response with no outstanding owner");
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized self-checking bench for mem_port_arbiter against a queue model
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int OPW   = MEM_OP_SIZE;
    localparam int DEPTH = 2;

    logic           CLK = 1'b0;
    logic           RST_N;
    logic           c0_put_enable, c0_put_ready, c0_get_enable, c0_get_ready;
    logic [OPW-1:0] c0_put_request, c0_get_response;
    logic           c1_put_enable, c1_put_ready, c1_get_enable, c1_get_ready;
    logic [OPW-1:0] c1_put_request, c1_get_response;
    logic           mem_put_enable, mem_put_ready, mem_get_enable, mem_get_ready;
    logic [OPW-1:0] mem_put_request, mem_get_response;
`ifdef ARB_STATS_EN
    logic [31:0]    stat_grants0, stat_grants1, stat_conflicts;
`endif

    always #5 CLK = ~CLK;

    mem_port_arbiter #(.OP_WIDTH(OPW), .OWNER_DEPTH(DEPTH)) dut (
        .CLK              (CLK),
        .RST_N            (RST_N),
        .c0_put_enable    (c0_put_enable),
        .c0_put_request   (c0_put_request),
        .c0_put_ready     (c0_put_ready),
        .c0_get_enable    (c0_get_enable),
        .c0_get_ready     (c0_get_ready),
        .c0_get_response  (c0_get_response),
        .c1_put_enable    (c1_put_enable),
        .c1_put_request   (c1_put_request),
        .c1_put_ready     (c1_put_ready),
        .c1_get_enable    (c1_get_enable),
        .c1_get_ready     (c1_get_ready),
        .c1_get_response  (c1_get_response),
        .mem_put_enable   (mem_put_enable),
        .mem_put_request  (mem_put_request),
        .mem_put_ready    (mem_put_ready),
        .mem_get_enable   (mem_get_enable),
        .mem_get_ready    (mem_get_ready),
        .mem_get_response (mem_get_response)
`ifdef ARB_STATS_EN
        ,
        .stat_grants0     (stat_grants0),
        .stat_grants1     (stat_grants1),
        .stat_conflicts   (stat_conflicts)
`endif
    );

    int n_pass = 0;
    int n_chk  = 0;

    // Reference state: who is owed the next response, what each client is owed, what memory holds.
    int             prio_m;
    int             order_q[$];
    logic [OPW-1:0] exp_q0[$], exp_q1[$], mem_q[$];
    int             glog[$];
    int             c0_gets, c1_gets;
    logic [31:0]    last_addr0, last_addr1;
    logic [3:0]     last_be1;

    int          pe0, pe1, pg0, pg1, pmp, pmg;
    bit          fix0, fix1, pend0, pend1, mget_gate;
    logic [31:0] faddr0, faddr1;
    logic [3:0]  fbe;

    task automatic check(input string tag, input logic [OPW-1:0] got, input logic [OPW-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [OPW-1:0] resp_of(input logic [OPW-1:0] r);
        return {r[OPW-1:32], ~r[31:0]};
    endfunction

    function automatic logic [OPW-1:0] new_req(input bit fx, input logic [31:0] fa);
        logic [3:0]  be;
        logic [31:0] a;
        be = fx ? fbe : 4'($urandom);
        a  = fx ? fa : 32'($urandom);
        return {be, a, 32'($urandom)};
    endfunction

    task automatic drive();
        if (!pend0) begin
            c0_put_enable  = ($urandom_range(99) < pe0);
            c0_put_request = new_req(fix0, faddr0);
        end
        if (!pend1) begin
            c1_put_enable  = ($urandom_range(99) < pe1);
            c1_put_request = new_req(fix1, faddr1);
        end
        c0_get_enable = ($urandom_range(99) < pg0);
        c1_get_enable = ($urandom_range(99) < pg1);
        mem_put_ready = ($urandom_range(99) < pmp);
        mget_gate     = ($urandom_range(99) < pmg);
    endtask

    task automatic cycle();
        bit can, e0, e1, x0, x1, g0, g1, gx;
        int k;
        mem_get_ready    = RST_N && mget_gate && (mem_q.size() > 0);
        mem_get_response = (mem_q.size() > 0) ? mem_q[0] : '0;
        #1;
        x0 = 0; x1 = 0; gx = 0; k = -1;
        if (!RST_N) begin
            check("rst_c0_put_ready", c0_put_ready, 0);
            check("rst_c1_put_ready", c1_put_ready, 0);
            check("rst_c0_get_ready", c0_get_ready, 0);
            check("rst_c1_get_ready", c1_get_ready, 0);
            check("rst_mem_put_enable", mem_put_enable, 0);
            check("rst_mem_get_enable", mem_get_enable, 0);
        end else begin
            can = mem_put_ready && (order_q.size() < DEPTH);
            e0  = can && (prio_m == 0 || !c1_put_enable);
            e1  = can && (prio_m == 1 || !c0_put_enable);
            x0  = c0_put_enable && e0;
            x1  = c1_put_enable && e1;
            check("c0_put_ready", c0_put_ready, e0);
            check("c1_put_ready", c1_put_ready, e1);
            check("mem_put_enable", mem_put_enable, x0 || x1);
            if (x0 || x1) check("mem_put_request", mem_put_request, x0 ? c0_put_request : c1_put_request);
            g0 = mem_get_ready && (order_q.size() > 0) && (order_q[0] == 0);
            g1 = mem_get_ready && (order_q.size() > 0) && (order_q[0] == 1);
            check("c0_get_ready", c0_get_ready, g0);
            check("c1_get_ready", c1_get_ready, g1);
            gx = (c0_get_enable && g0) || (c1_get_enable && g1);
            check("mem_get_enable", mem_get_enable, gx);
            if (gx) begin
                k = order_q[0];
                if (k == 0) begin
                    check("c0_get_response", c0_get_response, resp_of(exp_q0[0]));
                    c0_gets++;
                    last_addr0 = c0_get_response[ADDR_LSB +: 32];
                end else begin
                    check("c1_get_response", c1_get_response, resp_of(exp_q1[0]));
                    c1_gets++;
                    last_addr1 = c1_get_response[ADDR_LSB +: 32];
                    last_be1   = c1_get_response[BYTE_EN_LSB +: 4];
                end
            end
        end
        @(posedge CLK);
        if (!RST_N) begin
            order_q.delete(); exp_q0.delete(); exp_q1.delete(); mem_q.delete();
            prio_m = 0;
        end else begin
            if (x0) begin
                order_q.push_back(0); exp_q0.push_back(c0_put_request);
                mem_q.push_back(resp_of(c0_put_request)); prio_m = 1; glog.push_back(0);
            end
            if (x1) begin
                order_q.push_back(1); exp_q1.push_back(c1_put_request);
                mem_q.push_back(resp_of(c1_put_request)); prio_m = 0; glog.push_back(1);
            end
            if (gx) begin
                void'(order_q.pop_front());
                void'(mem_q.pop_front());
                if (k == 0) void'(exp_q0.pop_front());
                else void'(exp_q1.pop_front());
            end
        end
        pend0 = c0_put_enable && !x0;
        pend1 = c1_put_enable && !x1;
        @(negedge CLK);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            drive();
            cycle();
        end
    endtask

    task automatic set_knobs(input int a0, input int a1, input int b0, input int b1, input int mp, input int mg);
        pe0 = a0; pe1 = a1; pg0 = b0; pg1 = b1; pmp = mp; pmg = mg;
    endtask

    initial begin
        int iters, g0s, g1s;
        RST_N = 1'b0;
        c0_put_enable = 0; c1_put_enable = 0; c0_get_enable = 0; c1_get_enable = 0;
        c0_put_request = '0; c1_put_request = '0;
        mem_put_ready = 0; mem_get_ready = 0; mem_get_response = '0;
        prio_m = 0; pend0 = 0; pend1 = 0; fix0 = 0; fix1 = 0; fbe = '0;
        faddr0 = '0; faddr1 = '0; c0_gets = 0; c1_gets = 0;
        last_addr0 = '0; last_addr1 = '0; last_be1 = '0;
        @(negedge CLK);

        // Reset held with both clients requesting, then strict alternation from c0.
        set_knobs(100, 100, 100, 100, 100, 100);
        fix0 = 1; faddr0 = 32'h100; fix1 = 1; faddr1 = 32'h200; fbe = 4'b0000;
        run(3);
        RST_N = 1'b1;
        glog.delete();
        run(6);
        for (int i = 0; i < 6; i++) check($sformatf("alt_grant%0d", i), (i < glog.size()) ? glog[i] : -1, i % 2);
        set_knobs(0, 0, 100, 100, 100, 100);
        fix0 = 0; fix1 = 0;
        run(6);
        check("c0_resp_addr", last_addr0, 32'h100);
        check("c1_resp_addr", last_addr1, 32'h200);

        // Lone c1 requester gets back-to-back grants and leaves priority with c0.
        set_knobs(0, 100, 100, 100, 100, 100);
        glog.delete();
        iters = 0;
        while (iters < 20 && glog.size() < 4) begin
            run(1);
            iters++;
        end
        check("c1_b2b_cycles", iters, 4);
        foreach (glog[i]) check("c1_only_grant", glog[i], 1);
        set_knobs(100, 100, 100, 100, 100, 100);
        glog.delete();
        run(1);
        check("prio_back_to_c0", (glog.size() > 0) ? glog[0] : -1, 0);
        set_knobs(0, 0, 100, 100, 100, 100);
        run(6);

        // Owner FIFO full with responses held off: no bypass on the popping cycle.
        set_knobs(100, 0, 100, 100, 100, 0);
        glog.delete();
        run(4);
        check("full_blocks_third", glog.size(), 2);
        pmg = 100;
        run(1);
        check("full_no_bypass", glog.size(), 2);
        run(1);
        check("full_after_pop", glog.size(), 3);
        set_knobs(0, 0, 100, 100, 100, 100);
        run(6);

        // Head-of-line: c1 response waits for c0 to take its own.
        set_knobs(100, 0, 0, 100, 100, 0);
        run(1);
        set_knobs(0, 100, 0, 100, 100, 0);
        run(1);
        g0s = c0_gets; g1s = c1_gets;
        set_knobs(0, 0, 0, 100, 100, 100);
        run(3);
        check("head_block_c1", c1_gets - g1s, 0);
        pg0 = 100;
        run(3);
        check("head_drain_c0", c0_gets - g0s, 1);
        check("head_drain_c1", c1_gets - g1s, 1);

        // Reset with two tags outstanding, then a c1 store must route to c1 only.
        set_knobs(100, 0, 100, 100, 100, 0);
        run(2);
        set_knobs(0, 0, 100, 100, 100, 0);
        RST_N = 1'b0;
        run(1);
        RST_N = 1'b1;
        fix1 = 1; faddr1 = 32'h40; fbe = 4'b0011;
        g0s = c0_gets; g1s = c1_gets;
        set_knobs(0, 100, 100, 100, 100, 100);
        run(1);
        set_knobs(0, 0, 100, 100, 100, 100);
        run(3);
        check("mreset_c1_gets", c1_gets - g1s, 1);
        check("mreset_c0_gets", c0_gets - g0s, 0);
        check("mreset_addr", last_addr1, 32'h40);
        check("mreset_be", last_be1, 4'b0011);
        fix1 = 0;

        // Randomized traffic with occasional resets.
        for (int blk = 0; blk < 10; blk++) begin
            set_knobs($urandom_range(100), $urandom_range(100), $urandom_range(100),
                      $urandom_range(100), $urandom_range(30, 100), $urandom_range(30, 100));
            for (int i = 0; i < 50; i++) begin
                RST_N = ($urandom_range(99) != 0);
                run(1);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end

endmodule
